// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit scheduler.
// ST_PAD exists only when ETH_TX_PAD_EN is defined.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
`ifdef ETH_TX_PAD_EN
        ST_PAD,
`endif
        ST_GAP
    } tx_sched_state_t;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;
    localparam int         MIN_FRAME_BYTES = 60;
    localparam int         DEF_IFG_CYCLES  = 48;

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Requester-side byte handshake bus: valid/data/last towards the scheduler, ready back.
interface eth_tx_scheduler_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;

    modport master (output req_valid, req_data, req_last, input req_ready);
    modport slave  (input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          any_o
);
    int idx;

    // Walk offsets from high to low so the smallest offset is written last and wins.
    always_comb begin
        grant_o = '0;
        idx     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_i) + off) % N;
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin frame arbiter with preamble/SFD insertion, dibit serializer and inter-frame gap.
// Build option ETH_TX_PAD_EN pads short frames with zero bytes up to the minimum frame length.
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic              clk,
    input  logic              rst,
    eth_tx_scheduler_if.slave req,
    output logic [N_REQ-1:0]  grant,
    output logic              axiov,
    output logic [1:0]        axiod,
    output logic              busy,
    output logic              abort
);
    localparam int PRE_LEN = 4 * (PREAMBLE_BYTES + 1);
    localparam int PW      = $clog2(PRE_LEN);
    localparam int GW      = $clog2(IFG_CYCLES);
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tx_sched_state_t  state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [1:0]       k_q, k_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic             abort_q, abort_d;
    logic             axiov_q, axiov_d;
    logic [1:0]       axiod_q, axiod_d;
`ifdef ETH_TX_PAD_EN
    logic [5:0]       bcnt_q, bcnt_d;
`endif

    logic [N_REQ-1:0] arb_grant;
    logic             arb_any;
    logic [IW-1:0]    arb_idx;
    logic             sel_valid, sel_last, pre_end, rdy;
    logic [7:0]       sel_data;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req_i   (req.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    always_comb begin
        arb_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) arb_idx = IW'(i);
            if (grant_q[i])   sel_data = sel_data | req.req_data[8*i +: 8];
        end
    end

    assign sel_valid     = |(req.req_valid & grant_q);
    assign sel_last      = |(req.req_last & grant_q);
    assign pre_end       = (pcnt_q == PW'(PRE_LEN - 1));
    assign rdy           = (state_q == ST_PREAMBLE && pre_end) ||
                           (state_q == ST_DATA && k_q == 2'd3 && !last_q);
    assign req.req_ready = grant_q & {N_REQ{rdy}};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pcnt_d  = pcnt_q;
        gcnt_d  = gcnt_q;
        k_d     = k_q;
        byte_d  = byte_q;
        last_d  = last_q;
        abort_d = 1'b0;
`ifdef ETH_TX_PAD_EN
        bcnt_d  = bcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef ETH_TX_PAD_EN
                bcnt_d = '0;
`endif
                if (arb_any) begin
                    state_d = ST_PREAMBLE;
                    grant_d = arb_grant;
                    ptr_d   = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + IW'(1);
                    pcnt_d  = '0;
                end
            end
            ST_PREAMBLE: begin
                pcnt_d = pcnt_q + PW'(1);
                if (pre_end) begin
                    if (sel_valid) begin
                        state_d = ST_DATA;
                        byte_d  = sel_data;
                        last_d  = sel_last;
                        k_d     = '0;
`ifdef ETH_TX_PAD_EN
                        bcnt_d  = 6'd1;
`endif
                    end else begin
                        state_d = ST_GAP;
                        grant_d = '0;
                        gcnt_d  = '0;
                        abort_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (last_q) begin
                        state_d = ST_GAP;
                        grant_d = '0;
                        gcnt_d  = '0;
`ifdef ETH_TX_PAD_EN
                        if (bcnt_q < 6'(MIN_FRAME_BYTES)) begin
                            state_d = ST_PAD;
                            grant_d = grant_q;
                        end
`endif
                    end else if (sel_valid) begin
                        byte_d = sel_data;
                        last_d = sel_last;
`ifdef ETH_TX_PAD_EN
                        if (bcnt_q != 6'd63) bcnt_d = bcnt_q + 6'd1;
`endif
                    end else begin
                        state_d = ST_GAP;
                        grant_d = '0;
                        gcnt_d  = '0;
                        abort_d = 1'b1;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (bcnt_q == 6'(MIN_FRAME_BYTES - 1)) begin
                        state_d = ST_GAP;
                        grant_d = '0;
                        gcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 6'd1;
                    end
                end
            end
`endif
            ST_GAP: begin
                gcnt_d = gcnt_q + GW'(1);
                // The IDLE arbitration cycle supplies the final idle dibit of the gap.
                if (gcnt_q == GW'(IFG_CYCLES - 2)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered: decode them from the state being entered.
    always_comb begin
        axiov_d = 1'b0;
        axiod_d = 2'b00;
        case (state_d)
            ST_PREAMBLE: begin
                axiov_d = 1'b1;
                axiod_d = (pcnt_d == PW'(PRE_LEN - 1)) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
            end
            ST_DATA: begin
                axiov_d = 1'b1;
                axiod_d = byte_d[{k_d, 1'b0} +: 2];
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: axiov_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            pcnt_q  <= '0;
            gcnt_q  <= '0;
            k_q     <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
`ifdef ETH_TX_PAD_EN
            bcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            pcnt_q  <= pcnt_d;
            gcnt_q  <= gcnt_d;
            k_q     <= k_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            abort_q <= abort_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
`ifdef ETH_TX_PAD_EN
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign axiov = axiov_q;
    assign axiod = axiod_q;
    assign busy  = (state_q != ST_IDLE);
    assign abort = abort_q;
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Bench for eth_tx_scheduler: queued requesters plus a per-cycle expected output stream
// built from frame-level rules (preamble, LSB-first dibits, optional padding, gap).
module tb_eth_tx_scheduler;
    localparam int N   = 2;
    localparam int IFG = 48;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_tx_scheduler_if #(.N_REQ(N)) ifc ();
    logic [N-1:0] grant;
    logic         axiov, busy, abort;
    logic [1:0]   axiod;

    eth_tx_scheduler #(.N_REQ(N), .IFG_CYCLES(IFG), .PREAMBLE_BYTES(7)) dut (
        .clk(clk), .rst(rst), .req(ifc), .grant(grant),
        .axiov(axiov), .axiod(axiod), .busy(busy), .abort(abort)
    );

    typedef struct {
        logic         v;
        logic [1:0]   d;
        logic [N-1:0] g;
        logic         ab;
        logic         bz;
    } item_t;

    int          passed = 0;
    int          total  = 0;
    int          ptr_m  = 0;
    logic [8:0]  rq [N][$];
    logic [7:0]  fb [$];
    item_t       exp_q [$];

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ifc.req_valid[i]       = (rq[i].size() > 0);
            ifc.req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            ifc.req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    endtask

    // One clock: handshakes seen at the negedge complete on the posedge.
    task automatic cycle();
        logic [N-1:0] hs;
        hs = ifc.req_valid & ifc.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) void'(rq[i].pop_front());
        drive();
        @(negedge clk);
    endtask

    function automatic void push_item(logic v, logic [1:0] d, logic [N-1:0] g, logic ab, logic bz);
        item_t it;
        it.v = v; it.d = d; it.g = g; it.ab = ab; it.bz = bz;
        exp_q.push_back(it);
    endfunction

    // Random frame of n bytes for requester r; only the first keep bytes are ever offered.
    task automatic mk_frame(int r, int n, int keep);
        logic [7:0] b;
        fb = {};
        for (int i = 0; i < keep; i++) begin
            b = 8'($urandom);
            fb.push_back(b);
            rq[r].push_back({(i == n - 1), b});
        end
    endtask

    task automatic add_frame(int owner, bit aborted);
        logic [N-1:0] g;
        logic [7:0]   b;
        g = '0;
        g[owner] = 1'b1;
        for (int i = 0; i < 32; i++) push_item(1'b1, (i == 31) ? 2'b11 : 2'b01, g, 1'b0, 1'b1);
        foreach (fb[j]) begin
            b = fb[j];
            for (int k = 0; k < 4; k++) push_item(1'b1, 2'((b >> (2 * k)) & 8'h3), g, 1'b0, 1'b1);
        end
`ifdef ETH_TX_PAD_EN
        if (!aborted)
            for (int j = fb.size(); j < 60; j++)
                for (int k = 0; k < 4; k++) push_item(1'b1, 2'b00, g, 1'b0, 1'b1);
`endif
        for (int i = 0; i < IFG; i++) push_item(1'b0, 2'b00, '0, aborted && (i == 0), i != IFG - 1);
        ptr_m = (owner + 1) % N;
    endtask

    // All requesters in mask present a frame at once; they are served in round-robin order.
    task automatic round(logic [N-1:0] mask, int len0, int len1);
        int r;
        push_item(1'b0, 2'b00, '0, 1'b0, 1'b0);
        for (int off = 0; off < N; off++) begin
            r = (ptr_m + off) % N;
            if (mask[r]) begin
                mk_frame(r, (r == 0) ? len0 : len1, (r == 0) ? len0 : len1);
                add_frame(r, 1'b0);
            end
        end
        drive();
    endtask

    task automatic run_stream(string tag);
        item_t it;
        int    n;
        n = 0;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            chk($sformatf("%s cyc%0d {v,d,g,ab,busy}", tag, n),
                8'({axiov, axiod, grant, abort, busy}), 8'({it.v, it.d, it.g, it.ab, it.bz}));
            if ({axiov, axiod, grant, abort, busy} !== {it.v, it.d, it.g, it.ab, it.bz}) exp_q = {};
            else cycle();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i] = {};
        drive();
        cycle();
        cycle();
        rst = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        rst = 1'b1;
        drive();
        @(negedge clk);
        do_reset();

        chk("reset axiov", 8'(axiov), 8'h0);
        chk("reset axiod", 8'(axiod), 8'h0);
        chk("reset req_ready", 8'(ifc.req_ready), 8'h0);
        chk("reset grant", 8'(grant), 8'h0);
        chk("reset busy", 8'(busy), 8'h0);
        chk("reset abort", 8'(abort), 8'h0);

        // Directed single frame 0xA5, 0x3C from requester 0.
        push_item(1'b0, 2'b00, '0, 1'b0, 1'b0);
        rq[0].push_back({1'b0, 8'hA5});
        rq[0].push_back({1'b1, 8'h3C});
        fb = {8'hA5, 8'h3C};
        add_frame(0, 1'b0);
        drive();
        run_stream("single");
        chk("single idle busy", 8'(busy), 8'h0);

        // Underrun: 5-byte frame on requester 1, valid drops before byte 3.
        push_item(1'b0, 2'b00, '0, 1'b0, 1'b0);
        mk_frame(1, 5, 2);
        add_frame(1, 1'b1);
        drive();
        run_stream("underrun");

        // Contention right after reset, twice; second time the pointer has wrapped to 0.
        do_reset();
        round(2'b11, 1, int'($urandom_range(2, 6)));
        run_stream("contend1");
        round(2'b11, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
        run_stream("contend2");

        // Back-to-back: requester 0 holds three frames queued.
        push_item(1'b0, 2'b00, '0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            mk_frame(0, int'($urandom_range(1, 8)), 0);
            fb = {};
        end
        for (int i = 0; i < N; i++) rq[i] = {};
        for (int f = 0; f < 3; f++) begin
            mk_frame(0, (f == 1) ? 10 : int'($urandom_range(1, 8)), (f == 1) ? 10 : 0);
            if (fb.size() == 0) mk_frame(0, 3, 3);
            add_frame(0, 1'b0);
        end
        drive();
        run_stream("b2b");

        // Random rounds with random requester masks.
        for (int r = 0; r < 4; r++) begin
            round(2'($urandom_range(1, 3)), int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
            run_stream($sformatf("rand%0d", r));
        end

        // Reset mid-DATA, then a fresh request is served with no gap.
        mk_frame(0, 4, 4);
        drive();
        for (int i = 0; i < 36; i++) cycle();
        chk("pre-reset in frame", 8'(axiov), 8'h1);
        rst = 1'b1;
        cycle();
        chk("midreset axiov", 8'(axiov), 8'h0);
        chk("midreset busy", 8'(busy), 8'h0);
        chk("midreset grant", 8'(grant), 8'h0);
        rst = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) rq[i] = {};
        push_item(1'b0, 2'b00, '0, 1'b0, 1'b0);
        mk_frame(1, 2, 2);
        add_frame(1, 1'b0);
        drive();
        run_stream("postreset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Shares the single 2-bit RMII-style transmit dibit stream between N_REQ byte-stream requesters (e.g. frame builder, ARP responder).
- Round-robin grant at frame granularity; prepends preamble+SFD; serializes bytes LSB-dibit-first; enforces the inter-frame gap.
- Output feeds the downstream dibit path (bit reordering / CRC append) using the same axiov/axiod convention.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- IFG_CYCLES, 48, idle dibit cycles between frames (96 bit times).
- PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD 0xD5.

Ports:
- clk  in  1  system clock, one dibit per cycle.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
- req_last  in  N_REQ  marks final byte of the frame.
- req_ready  out  N_REQ  byte accepted when valid&ready.
- grant  out  N_REQ  one-hot owner of current frame; 0 when idle/gap.
- axiov  out  1  output dibit valid.
- axiod  out  2  output dibit.
- busy  out  1  high in any state but IDLE.
- abort  out  1  one-cycle pulse on underrun abort.

Behaviour:
- Reset: axiov=0, axiod=2'b00, req_ready=0, grant=0, busy=0, abort=0. State=IDLE, round-robin pointer=0, all counters=0. Reset mid-frame takes effect next edge: stream cut, no gap inserted.
- States: IDLE, PREAMBLE, DATA, PAD (PAD only with the optional feature), GAP.
- IDLE:
  - If any req_valid, grant the first valid index searching from pointer upward (wrapping).
  - Next cycle: state=PREAMBLE, grant registered, pointer=granted+1 mod N_REQ.
  - req_valid is sampled only; no byte is consumed in IDLE.
- PREAMBLE:
  - axiov=1 for 4*(PREAMBLE_BYTES+1) cycles (32 by default).
  - axiod=2'b01 on all but the last cycle; last cycle 2'b11 (0xD5 LSB-first).
  - On the last cycle, req_ready[grant]=1. If valid, load the byte and go to DATA with dibit index 0. Otherwise pulse abort and go to GAP.
- DATA:
  - axiod=byte[2k+1:2k] for dibit index k=0..3; axiov=1.
  - At k=3, req_ready[grant]=1 unless the held byte was last:
    - valid: load next byte and continue.
    - not valid: abort pulse, axiov low next cycle, go to GAP.
  - Held byte last and k=3: no ready; go to GAP (or PAD).
- req_ready is combinational from state, index and grant; it is never high for non-granted requesters. Sustained throughput is 1 byte per 4 cycles with no bubbles.
- GAP: axiov=0, axiod=0, grant=0. Count IFG_CYCLES, then IDLE. Requests arriving during GAP wait; arbitration happens only in IDLE.
- Byte counter: 6 bits, saturating at 63; counts data bytes in the frame and clears in IDLE.
- req_last is sampled together with the byte on handshake. A frame of a single byte (last on first byte) is legal.
- No fairness across aborts: pointer has already advanced.

Optional Feature:
- Macro ETH_TX_PAD_EN.
- Defined: if the data byte count < 60 when the last byte finishes, enter PAD and emit 0x00 bytes (axiod=00, axiov=1) until the total reaches 60, then GAP. No req_ready is asserted in PAD.
- Undefined: PAD state and its logic are absent; short frames go directly to GAP.

Decomposition:
- Package eth_pkg:
  - state enum tx_sched_state_t;
  - PREAMBLE_DIBIT=2'b01, SFD_LAST_DIBIT=2'b11;
  - MIN_FRAME_BYTES=60;
  - default IFG_CYCLES.
- One sub-module, rr_arbiter: parameter N; inputs req vector, pointer; output one-hot grant plus any_req. Purely combinational priority search; pointer register lives in the parent.

Test Plan:
- Single frame: req 0 sends 0xA5,0x3C (last) → axiov rises 1 cycle after valid; 31×01, 11, then dibits 01,01,10,10,00,11,11,00; then 48 idle cycles.
- Contention: both valid at the same cycle after reset → req0 frame first, then req1 after the gap. Both again → req0 (pointer wrapped).
- Underrun: req1 drops valid before byte 3 of a 5-byte frame → abort=1 for one cycle, axiov=0 next cycle, grant=0, gap of 48 cycles.
- Reset mid-DATA: rst high for 1 cycle → next cycle axiov=0, busy=0, grant=0; a new request is granted immediately with no gap.
- Back-to-back: req0 holds valid continuously for 3 frames with req1 idle → each frame separated by exactly 48 cycles of axiov=0, and 4 cycles per byte with no bubbles.
- With ETH_TX_PAD_EN: 10-byte frame → 50 zero bytes (200 dibits of 00 with axiov=1) follow before the gap. Without it → gap starts immediately after byte 10.
